// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and default widths for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_M   = 2;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW:0]    pos;
  logic           found;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path infers a latch.
    gnt_o = '0;
    found = 1'b0;
    pos   = '0;
    dbl   = {req_i, req_i};
    rot   = dbl[ptr_i +: N];
    // Lowest set bit of the rotated vector is the winner; un-rotate its index.
    for (int k = 0; k < N; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        pos   = {1'b0, ptr_i} + (PW+1)'(k);
        if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
        gnt_o[pos[PW-1:0]] = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: grant locked per CYC, watchdog ends hung cycles with ERR.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M   = DEF_NUM_M,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [NUM_M-1:0]    M_CYC_I,
  input  logic [NUM_M-1:0]    M_STB_I,
  input  logic [NUM_M-1:0]    M_WE_I,
  input  logic [NUM_M*AW-1:0] M_ADR_I,
  input  logic [NUM_M*DW-1:0] M_DAT_I,
  output logic [NUM_M-1:0]    M_ACK_O,
  output logic [NUM_M-1:0]    M_ERR_O,
  output logic [DW-1:0]       M_DAT_O,
  output logic                S_CYC_O,
  output logic                S_STB_O,
  output logic                S_WE_O,
  output logic [AW-1:0]       S_ADR_O,
  output logic [DW-1:0]       S_DAT_O,
  input  logic                S_ACK_I,
  input  logic [DW-1:0]       S_DAT_I,
  output logic [NUM_M-1:0]    GNT_O
);

  localparam int PW  = $clog2(NUM_M);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;

  logic [NUM_M-1:0] pick_gnt;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    ptr_next;
  logic             busy;

  rr_pick #(.N(NUM_M), .PW(PW)) u_pick (
    .req_i   (M_CYC_I),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_M; i++)
      if (pick_gnt[i]) pick_idx = PW'(i);
  end

  assign ptr_next = (gidx_q == PW'(NUM_M - 1)) ? '0 : gidx_q + 1'b1;
  assign busy     = (state_q == BUSY);

  // Slave side follows the granted master combinationally so ACK keeps zero-wait timing.
  always_comb begin
    S_CYC_O = 1'b0;
    S_STB_O = 1'b0;
    S_WE_O  = 1'b0;
    S_ADR_O = '0;
    S_DAT_O = '0;
    if (busy) begin
      S_CYC_O = M_CYC_I[gidx_q];
      S_STB_O = M_STB_I[gidx_q];
      S_WE_O  = M_WE_I[gidx_q];
      S_ADR_O = M_ADR_I[int'(gidx_q)*AW +: AW];
      S_DAT_O = M_DAT_I[int'(gidx_q)*DW +: DW];
    end
    M_ACK_O = (busy && S_STB_O && S_ACK_I) ? gnt_q : '0;
    M_ERR_O = err_q ? gnt_q : '0;
  end

  assign M_DAT_O = S_DAT_I;
  assign GNT_O   = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wd_d    = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
        end
      end
      BUSY: begin
        if (!M_CYC_I[gidx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end else if (S_STB_O && !S_ACK_I) begin
          if (wd_q == WD_LAST) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      ERR: begin
        if (!M_CYC_I[gidx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (2 masters, TIMEOUT=8).
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NM-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
  logic [NM*AW-1:0] m_adr = '0;
  logic [NM*DW-1:0] m_dat = '0;
  logic [NM-1:0]    m_ack, m_err, gnt;
  logic [DW-1:0]    m_dat_o, s_dat_o, s_dat_i = '0;
  logic [AW-1:0]    s_adr;
  logic             s_cyc, s_stb, s_we, s_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  wb_rr_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .M_CYC_I (m_cyc),
    .M_STB_I (m_stb),
    .M_WE_I  (m_we),
    .M_ADR_I (m_adr),
    .M_DAT_I (m_dat),
    .M_ACK_O (m_ack),
    .M_ERR_O (m_err),
    .M_DAT_O (m_dat_o),
    .S_CYC_O (s_cyc),
    .S_STB_O (s_stb),
    .S_WE_O  (s_we),
    .S_ADR_O (s_adr),
    .S_DAT_O (s_dat_o),
    .S_ACK_I (s_ack),
    .S_DAT_I (s_dat_i),
    .GNT_O   (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = we;
    m_adr[i*AW +: AW] = adr;
    m_dat[i*DW +: DW] = dat;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_ack", m_ack, 2'b00);
    chk("rst_err", m_err, 2'b00);
    tick();
    rst = 1'b0;

    // 1: single write, ACK on the 5th BUSY cycle
    drive(0, 1, 1, 1, 32'h0, 32'h30201);
    settle();
    chk("t1_latency_gnt", gnt, 2'b00);
    tick();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_sdat", s_dat_o, 32'h30201);
    chk("t1_ctl", {s_cyc, s_stb, s_we}, 3'b111);
    for (int c = 0; c < 4; c++) begin
      chk("t1_wait_ack", m_ack, 2'b00);
      tick();
    end
    s_ack = 1'b1;
    settle();
    chk("t1_ack", m_ack, 2'b01);
    tick();
    s_ack = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    settle();
    chk("t1_ack_gone", m_ack, 2'b00);
    chk("t1_gnt_held", gnt, 2'b01);
    tick();
    chk("t1_release", gnt, 2'b00);

    // 2: simultaneous requests after reset
    do_reset();
    drive(0, 1, 1, 0, 32'h10, 32'h0);
    drive(1, 1, 1, 0, 32'h20, 32'h0);
    settle();
    chk("t2_idle", gnt, 2'b00);
    tick();
    chk("t2_first", gnt, 2'b01);
    chk("t2_adr0", s_adr, 32'h10);
    s_ack = 1'b1;
    settle();
    chk("t2_ack0", m_ack, 2'b01);
    tick();
    s_ack = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("t2_gap", gnt, 2'b00);
    chk("t2_gap_scyc", s_cyc, 1'b0);
    tick();
    chk("t2_second", gnt, 2'b10);
    chk("t2_adr1", s_adr, 32'h20);
    s_dat_i = 32'hDEADBEEF;
    s_ack = 1'b1;
    settle();
    chk("t2_ack1", m_ack, 2'b10);
    chk("t2_rdata", m_dat_o, 32'hDEADBEEF);
    tick();
    s_ack = 1'b0;
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("t2_done", gnt, 2'b00);

    // 3: fairness, M0 re-requests at once while M1 waits
    drive(0, 1, 1, 1, 32'h4, 32'h11);
    drive(1, 1, 1, 1, 32'h8, 32'h22);
    tick();
    chk("t3_m0", gnt, 2'b01);
    s_ack = 1'b1;
    settle();
    chk("t3_ack0", m_ack, 2'b01);
    tick();
    s_ack = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 1, 1, 0, 32'h4, 32'h0);
    settle();
    chk("t3_gap", gnt, 2'b00);
    tick();
    chk("t3_m1_wins", gnt, 2'b10);
    chk("t3_sdat1", s_dat_o, 32'h22);
    s_ack = 1'b1;
    settle();
    chk("t3_ack1", m_ack, 2'b10);
    tick();
    s_ack = 1'b0;
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    tick();

    // 4: timeout, slave never ACKs
    tick();
    chk("t4_gnt", gnt, 2'b01);
    chk("t4_stb0", s_stb, 1'b1);
    for (int c = 1; c < 8; c++) begin
      tick();
      chk("t4_no_err", m_err, 2'b00);
    end
    tick();
    chk("t4_err", m_err, 2'b01);
    chk("t4_stb_off", s_stb, 1'b0);
    chk("t4_cyc_off", s_cyc, 1'b0);
    tick();
    chk("t4_err_1cyc", m_err, 2'b00);
    chk("t4_gnt_kept", gnt, 2'b01);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("t4_idle", gnt, 2'b00);

    // 5: reset during BUSY (pointer is 1, so M1 is granted first)
    drive(0, 1, 1, 0, 32'h0, 32'h0);
    drive(1, 1, 1, 0, 32'h0, 32'h0);
    tick();
    chk("t5_m1", gnt, 2'b10);
    s_ack = 1'b1;
    rst = 1'b1;
    settle();
    chk("t5_async_gnt", gnt, 2'b00);
    chk("t5_async_ctl", {s_cyc, s_stb}, 2'b00);
    chk("t5_async_ack", m_ack, 2'b00);
    s_ack = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("t5_idle", gnt, 2'b00);
    tick();
    chk("t5_from_m0", gnt, 2'b01);

    // 6: abort -- M1 drops CYC before ACK, late ACK dropped
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 1, 0, 0, 32'h0, 32'h0);
    tick();
    tick();
    chk("t6_m1", gnt, 2'b10);
    s_ack = 1'b1;
    settle();
    chk("t6_ack_no_stb", m_ack, 2'b00);
    s_ack = 1'b0;
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    s_ack = 1'b1;
    settle();
    chk("t6_late_ack", m_ack, 2'b00);
    chk("t6_idle", gnt, 2'b00);
    tick();
    s_ack = 1'b0;
    drive(0, 1, 1, 0, 32'h0, 32'h0);
    drive(1, 1, 1, 0, 32'h0, 32'h0);
    tick();
    chk("t6_ptr0", gnt, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
